load_align_unit: RTL and testbench

Parametrised load alignment unit between the LSU address stage and the word-oriented data memory. It accepts one load request at a time and issues one or two aligned word reads, two when the access crosses a word boundary. It then extracts the addressed bytes, sign- or zero-extends them and returns the result through a valid/ready response port. It generalises the combinational byte/half/word read aligner with unsigned loads, a configurable data width, misaligned-access support and a memory handshake.

---
 rtl/load_pkg.sv | 20 ++
 rtl/load_align_unit_if.sv | 38 +++
 rtl/load_extend.sv | 39 +++
 rtl/load_align_unit.sv | 126 ++++++++++++
 tb/tb_load_align_unit.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/load_pkg.sv
// Shared types and width helpers for the load alignment path.
package load_pkg;

   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;

   typedef enum logic [2:0] {IDLE, RD0, WAIT0, RD1, WAIT1, RESP} state_e;

   function automatic int bytes_of(input int data_w);
      return data_w / 8;
   endfunction

   function automatic int off_bits(input int data_w);
      return $clog2(data_w / 8);
   endfunction

   function automatic int size_bytes(input logic [1:0] size);
      return 1 << size;
   endfunction

endpackage

// File: rtl/load_align_unit_if.sv
// Request, memory and response handshakes of the load alignment unit.
interface load_align_unit_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic              mem_req_valid;
   logic              mem_req_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_err;

   modport slave (
      input  req_valid, req_addr, req_size, req_unsigned,
      output req_ready,
      output mem_req_valid, mem_addr,
      input  mem_req_ready, mem_rvalid, mem_rdata,
      output rsp_valid, rsp_data, rsp_err,
      input  rsp_ready
   );

   modport master (
      output req_valid, req_addr, req_size, req_unsigned,
      input  req_ready,
      input  mem_req_valid, mem_addr,
      output mem_req_ready, mem_rvalid, mem_rdata,
      input  rsp_valid, rsp_data, rsp_err,
      output rsp_ready
   );
endinterface

// File: rtl/load_extend.sv
// Shifts {hi, lo} down by the byte offset, keeps the addressed bytes and
// sign- or zero-extends them to the full word.
module load_extend
   import load_pkg::*;
#(
   parameter int DATA_W = 32,
   localparam int OFF_W = off_bits(DATA_W)
) (
   input  logic [DATA_W-1:0] hi_i,
   input  logic [DATA_W-1:0] lo_i,
   input  logic [OFF_W-1:0]  off_i,
   input  logic [1:0]        size_i,
   input  logic              unsigned_i,
   output logic [DATA_W-1:0] data_o
);
   logic [DATA_W-1:0] shifted;
   logic [7:0]        nbits;
   logic              sign_bit;

   assign shifted = DATA_W'({hi_i, lo_i} >> {off_i, 3'b000});
   assign nbits   = 8'(size_bytes(size_i) * 8);

   always_comb begin
      sign_bit = shifted[DATA_W-1];
      case (size_i)
         SZ_B:    sign_bit = shifted[7];
         SZ_H:    sign_bit = shifted[15];
         SZ_W:    sign_bit = shifted[31];
         default: sign_bit = shifted[DATA_W-1];
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < DATA_W; gi++) begin : g_bit
         assign data_o[gi] = (8'(gi) < nbits) ? shifted[gi] : (sign_bit & ~unsigned_i);
      end
   endgenerate
endmodule

// File: rtl/load_align_unit.sv
// Load alignment unit: one request at a time, one or two aligned word reads,
// then an extended result on a valid/ready response port.
module load_align_unit
   import load_pkg::*;
#(
   parameter int DATA_W           = 32,
   parameter int ADDR_W           = 32,
   parameter int ALLOW_MISALIGNED = 1
) (
   input logic               clk,
   input logic               rst,
   load_align_unit_if.slave  bus
);
   localparam int BYTES = bytes_of(DATA_W);
   localparam int OFF_W = off_bits(DATA_W);

   state_e            state_q;
   logic [OFF_W-1:0]  off_q;
   size_e             size_q;
   logic              uns_q;
   logic              cross_q;
   logic [DATA_W-1:0] lo_q;
   logic              mem_req_valid_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic              rsp_valid_q;
   logic [DATA_W-1:0] rsp_data_q;
   logic              rsp_err_q;

   logic              cross_d;
   logic              illegal_d;
   logic [ADDR_W-1:0] word_addr_d;
   logic [DATA_W-1:0] ext_hi;
   logic [DATA_W-1:0] ext_lo;
   logic [DATA_W-1:0] ext_data;

   assign cross_d     = (int'(bus.req_addr[OFF_W-1:0]) + size_bytes(bus.req_size)) > BYTES;
   assign illegal_d   = (size_bytes(bus.req_size) > BYTES) || (cross_d && (ALLOW_MISALIGNED == 0));
   assign word_addr_d = {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

   // In WAIT1 the arriving word is the high half; otherwise it is the only word.
   assign ext_hi = (state_q == WAIT1) ? bus.mem_rdata : '0;
   assign ext_lo = (state_q == WAIT1) ? lo_q : bus.mem_rdata;

   load_extend #(.DATA_W(DATA_W)) u_extend (
      .hi_i       (ext_hi),
      .lo_i       (ext_lo),
      .off_i      (off_q),
      .size_i     (size_q),
      .unsigned_i (uns_q),
      .data_o     (ext_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         off_q           <= '0;
         size_q          <= SZ_B;
         uns_q           <= 1'b0;
         cross_q         <= 1'b0;
         lo_q            <= '0;
         mem_req_valid_q <= 1'b0;
         mem_addr_q      <= '0;
         rsp_valid_q     <= 1'b0;
         rsp_data_q      <= '0;
         rsp_err_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (bus.req_valid) begin
               off_q   <= bus.req_addr[OFF_W-1:0];
               size_q  <= size_e'(bus.req_size);
               uns_q   <= bus.req_unsigned;
               cross_q <= cross_d;
               if (illegal_d) begin
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  rsp_data_q  <= '0;
                  state_q     <= RESP;
               end else begin
                  mem_addr_q      <= word_addr_d;
                  mem_req_valid_q <= 1'b1;
                  state_q         <= RD0;
               end
            end
            RD0: if (bus.mem_req_ready) begin
               mem_req_valid_q <= 1'b0;
               state_q         <= WAIT0;
            end
            WAIT0: if (bus.mem_rvalid) begin
               lo_q <= bus.mem_rdata;
               if (cross_q) begin
                  mem_addr_q      <= mem_addr_q + ADDR_W'(BYTES);
                  mem_req_valid_q <= 1'b1;
                  state_q         <= RD1;
               end else begin
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b0;
                  rsp_data_q  <= ext_data;
                  state_q     <= RESP;
               end
            end
            RD1: if (bus.mem_req_ready) begin
               mem_req_valid_q <= 1'b0;
               state_q         <= WAIT1;
            end
            WAIT1: if (bus.mem_rvalid) begin
               rsp_valid_q <= 1'b1;
               rsp_err_q   <= 1'b0;
               rsp_data_q  <= ext_data;
               state_q     <= RESP;
            end
            RESP: if (bus.rsp_ready) begin
               rsp_valid_q <= 1'b0;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_ready     = (state_q == IDLE) && !rst;
   assign bus.mem_req_valid = mem_req_valid_q;
   assign bus.mem_addr      = mem_addr_q;
   assign bus.rsp_valid     = rsp_valid_q;
   assign bus.rsp_data      = rsp_data_q;
   assign bus.rsp_err       = rsp_err_q;
endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit: byte-level memory model, scoreboard compare
// process, directed scenarios and a randomized request stream.
module tb_load_align_unit;
   localparam int DW = 32;
   localparam int AW = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   load_align_unit_if #(.DATA_W(DW), .ADDR_W(AW)) bus  ();
   load_align_unit_if #(.DATA_W(DW), .ADDR_W(AW)) bus2 ();

   load_align_unit #(.DATA_W(DW), .ADDR_W(AW), .ALLOW_MISALIGNED(1)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   load_align_unit #(.DATA_W(DW), .ADDR_W(AW), .ALLOW_MISALIGNED(0)) u_dut_na (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   typedef struct { logic [31:0] data; logic err; } exp_t;
   typedef struct { logic [31:0] addr; int due; } rd_t;

   exp_t        exp_q[$];
   logic [31:0] rd_exp[$];
   rd_t         pend[$];
   logic [31:0] rd_hist[$];

   int n_vec = 0, n_err = 0, cyc = 0, rd_cnt = 0, mrv2_cnt = 0;
   int mem_rdy_pct = 100, mem_dly_min = 1, mem_dly_max = 1;
   logic acc_f = 1'b0, mhs_f = 1'b0, rhs_f = 1'b0, rst_f = 1'b1;
   logic [31:0] mhs_addr = '0;
   logic pend2 = 1'b0;
   logic [31:0] pend2_addr = '0;

   function automatic logic [31:0] mem_word(input logic [31:0] wa);
      if (wa == 32'h100) return 32'h8899AABB;
      if (wa == 32'h104) return 32'h11223344;
      return (wa * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      logic [31:0] w;
      w = mem_word({a[31:2], 2'b00});
      w = w >> (8 * int'(a[1:0]));
      return w[7:0];
   endfunction

   // Result assembled byte by byte from memory, then extended.
   function automatic exp_t model(input logic [31:0] a, input logic [1:0] sz,
                                  input logic u, input bit allow_mis);
      exp_t r;
      int nb, off;
      nb = 1 << sz;
      off = int'(a[1:0]);
      r.data = '0;
      r.err = (nb > 4) || (!allow_mis && (off + nb > 4));
      if (!r.err) begin
         for (int k = 0; k < nb; k++) r.data = r.data | (32'(mem_byte(a + 32'(k))) << (8 * k));
         if (!u && r.data[8 * nb - 1]) for (int i = 8 * nb; i < 32; i++) r.data[i] = 1'b1;
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input logic [63:0] act);
      n_vec++;
      n_err++;
      $display("FAIL %s: got 0x%0h, want none", name, act);
   endtask

   // One clock: drive memory sides, record what the coming edge does, advance.
   task automatic cycle();
      exp_t e;
      rd_t r;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = $urandom;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         bus.mem_rvalid = 1'b1;
         bus.mem_rdata  = mem_word(pend[0].addr);
         void'(pend.pop_front());
      end
      bus.mem_req_ready  = ($urandom_range(99) < mem_rdy_pct);
      bus2.mem_req_ready = 1'b1;
      bus2.mem_rvalid    = pend2;
      bus2.mem_rdata     = pend2 ? mem_word(pend2_addr) : 32'h0;
      #1;
      acc_f = !rst && bus.req_valid && bus.req_ready;
      if (acc_f) begin
         e = model(bus.req_addr, bus.req_size, bus.req_unsigned, 1'b1);
         exp_q.push_back(e);
         if (!e.err) begin
            rd_exp.push_back({bus.req_addr[31:2], 2'b00});
            if (int'(bus.req_addr[1:0]) + (1 << bus.req_size) > 4)
               rd_exp.push_back({bus.req_addr[31:2], 2'b00} + 32'd4);
         end
      end
      mhs_f = !rst && bus.mem_req_valid && bus.mem_req_ready;
      mhs_addr = bus.mem_addr;
      if (mhs_f) begin
         r.addr = mhs_addr;
         r.due = cyc + int'($urandom_range(mem_dly_max, mem_dly_min));
         pend.push_back(r);
         rd_cnt++;
         rd_hist.push_back(mhs_addr);
      end
      rhs_f = !rst && bus.rsp_valid && bus.rsp_ready;
      rst_f = rst;
      pend2 = !rst && bus2.mem_req_valid;
      pend2_addr = bus2.mem_addr;
      if (bus2.mem_req_valid) mrv2_cnt++;
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   // Compare process: checks the DUT outputs after every edge.
   initial begin
      logic [31:0] w;
      forever begin
         @(posedge clk);
         #1;
         if (rst_f) begin
            exp_q.delete();
            rd_exp.delete();
            chk("rst_ctrl", {bus.req_ready, bus.mem_req_valid, bus.rsp_valid, bus.rsp_err}, 4'b0000);
            chk("rst_mem_addr", bus.mem_addr, 32'h0);
            chk("rst_rsp_data", bus.rsp_data, 32'h0);
         end else begin
            if (mhs_f) begin
               if (rd_exp.size() == 0) fail_now("mem_rd_unexpected", mhs_addr);
               else begin
                  w = rd_exp.pop_front();
                  chk("mem_addr", mhs_addr, w);
               end
            end
            if (rhs_f && exp_q.size() > 0) void'(exp_q.pop_front());
            if (bus.rsp_valid) begin
               if (exp_q.size() == 0) fail_now("rsp_spurious", bus.rsp_data);
               else begin
                  chk("rsp_data", bus.rsp_data, exp_q[0].data);
                  chk("rsp_err", bus.rsp_err, exp_q[0].err);
                  chk("busy_ctrl", {bus.req_ready, bus.mem_req_valid}, 2'b00);
               end
            end
         end
      end
   end

   task automatic run_req(input logic [31:0] a, input logic [1:0] sz, input logic u,
                          input int want_lat, input logic [31:0] want_d, input logic want_e,
                          input int want_rd, input int hold);
      int lat, rd0;
      logic [31:0] d0;
      rd0 = rd_cnt;
      bus.req_addr = a; bus.req_size = sz; bus.req_unsigned = u;
      bus.req_valid = 1'b1;
      bus.rsp_ready = (hold == 0);
      lat = 0;
      while (!bus.req_ready && lat < 50) begin cycle(); lat++; end
      cycle();
      bus.req_valid = 1'b0;
      lat = 1;
      while (!bus.rsp_valid && lat < 50) begin cycle(); lat++; end
      chk("latency", lat, want_lat);
      chk("lit_data", bus.rsp_data, want_d);
      chk("lit_err", bus.rsp_err, want_e);
      for (int i = 0; i < hold; i++) begin
         d0 = bus.rsp_data;
         cycle();
         chk("hold_ctrl", {bus.rsp_valid, bus.req_ready}, 2'b10);
         chk("hold_data", bus.rsp_data, d0);
      end
      bus.rsp_ready = 1'b1;
      cycle();
      chk("mem_reads", rd_cnt - rd0, want_rd);
      $display("load addr=%08h size=%0d uns=%0d -> data=%08h err=%0d lat=%0d reads=%0d",
               a, sz, u, want_d, want_e, lat, rd_cnt - rd0);
   endtask

   task automatic run_req2(input logic [31:0] a, input logic [1:0] sz, input logic u,
                           input logic [31:0] want_d, input logic want_e);
      int n, m0;
      m0 = mrv2_cnt;
      bus2.req_addr = a; bus2.req_size = sz; bus2.req_unsigned = u;
      bus2.req_valid = 1'b1;
      bus2.rsp_ready = 1'b1;
      n = 0;
      while (!bus2.req_ready && n < 50) begin cycle(); n++; end
      cycle();
      bus2.req_valid = 1'b0;
      n = 1;
      while (!bus2.rsp_valid && n < 50) begin cycle(); n++; end
      chk("na_latency", n, want_e ? 1 : 3);
      chk("na_data", bus2.rsp_data, want_d);
      chk("na_err", bus2.rsp_err, want_e);
      cycle();
      chk("na_mem_reqs", mrv2_cnt - m0, want_e ? 0 : 1);
      $display("na load addr=%08h size=%0d -> data=%08h err=%0d", a, sz, want_d, want_e);
   endtask

   initial begin
      exp_t e;
      int n;
      logic [31:0] a;
      bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_size = '0; bus.req_unsigned = 1'b0;
      bus.rsp_ready = 1'b0; bus.mem_req_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
      bus2.req_valid = 1'b0; bus2.req_addr = '0; bus2.req_size = '0; bus2.req_unsigned = 1'b0;
      bus2.rsp_ready = 1'b0; bus2.mem_req_ready = 1'b0; bus2.mem_rvalid = 1'b0; bus2.mem_rdata = '0;
      @(negedge clk);
      rst = 1'b1;
      repeat (3) cycle();
      rst = 1'b0;
      cycle();
      chk("idle_req_ready", bus.req_ready, 1'b1);

      // Zero-wait memory for the latency scenarios.
      run_req(32'h101, 2'd0, 1'b0, 3, 32'hFFFFFFAA, 1'b0, 1, 0);
      run_req(32'h103, 2'd1, 1'b1, 5, 32'h00004488, 1'b0, 2, 0);
      chk("cross_rd0", rd_hist[$ - 1], 32'h100);
      chk("cross_rd1", rd_hist[$], 32'h104);
      run_req(32'h102, 2'd2, 1'b0, 5, 32'h33448899, 1'b0, 2, 0);
      run_req(32'h100, 2'd3, 1'b0, 1, 32'h0, 1'b1, 0, 0);
      run_req(32'h102, 2'd1, 1'b0, 3, 32'hFFFF8899, 1'b0, 1, 0);
      e = model(32'hFFFFFFFE, 2'd2, 1'b0, 1'b1);
      run_req(32'hFFFFFFFE, 2'd2, 1'b0, 5, e.data, 1'b0, 2, 5);
      chk("wrap_rd0", rd_hist[$ - 1], 32'hFFFFFFFC);
      chk("wrap_rd1", rd_hist[$], 32'h0);

      run_req2(32'h102, 2'd2, 1'b0, 32'h0, 1'b1);
      run_req2(32'h103, 2'd1, 1'b1, 32'h0, 1'b1);
      run_req2(32'h100, 2'd2, 1'b0, 32'h8899AABB, 1'b0);

      // Reset while waiting for read data; the late rvalid must be ignored.
      mem_dly_min = 3; mem_dly_max = 3;
      bus.req_addr = 32'h100; bus.req_size = 2'd2; bus.req_unsigned = 1'b0;
      bus.req_valid = 1'b1; bus.rsp_ready = 1'b1;
      cycle();
      bus.req_valid = 1'b0;
      cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      mem_dly_min = 1; mem_dly_max = 1;
      repeat (4) cycle();
      chk("post_rst_idle", {bus.rsp_valid, bus.mem_req_valid, bus.req_ready}, 3'b001);
      $display("reset in WAIT0, stray rvalid delivered after abort");
      run_req(32'h100, 2'd0, 1'b0, 3, 32'hFFFFFFBB, 1'b0, 1, 0);

      // Randomized stream: stalling memory, random delays, random backpressure.
      mem_rdy_pct = 70; mem_dly_min = 1; mem_dly_max = 3;
      for (int t = 0; t < 300; t++) begin
         case ($urandom_range(3))
            0:       a = 32'h100 + 32'($urandom_range(7));
            1:       a = 32'hFFFFFFF8 + 32'($urandom_range(7));
            default: a = $urandom;
         endcase
         bus.req_addr = a;
         bus.req_size = 2'($urandom_range(3));
         bus.req_unsigned = 1'($urandom_range(1));
         bus.req_valid = 1'b1;
         n = 0;
         do begin
            bus.rsp_ready = ($urandom_range(99) < 60);
            cycle();
            n++;
         end while (!acc_f && n < 200);
         if (!acc_f) fail_now("accept_timeout", a);
         bus.req_valid = 1'b0;
         repeat ($urandom_range(2)) begin
            bus.rsp_ready = ($urandom_range(99) < 60);
            cycle();
         end
      end
      bus.rsp_ready = 1'b1;
      n = 0;
      while ((exp_q.size() > 0 || bus.rsp_valid) && n < 200) begin cycle(); n++; end
      chk("drain_rsp", exp_q.size(), 0);
      chk("drain_rd", rd_exp.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
